// File: rtl/dp_vid_mon.sv
// Passive DPRX video stream monitor: measures line length, line count and data checksum per frame,
// counts frames, flags framing errors and reports lock once consecutive frames share one format.
module dp_vid_mon #(
  parameter int P_PPC         = 4,
  parameter int P_VID_DAT     = 96,
  parameter int P_LOCK_FRAMES = 2
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic                 CLR_IN,
  input  logic                 VID_SOF_IN,
  input  logic                 VID_EOL_IN,
  input  logic [P_VID_DAT-1:0] VID_DAT_IN,
  input  logic                 VID_VLD_IN,
  output logic                 LOCK_OUT,
  output logic [15:0]          HRES_OUT,
  output logic [15:0]          VRES_OUT,
  output logic [P_VID_DAT-1:0] CHK_OUT,
  output logic [15:0]          FRM_CNT_OUT,
  output logic                 FRM_STB_OUT,
  output logic [2:0]           ERR_OUT
);

  localparam logic [3:0] LOCK_N = 4'(P_LOCK_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_EOL} state_t;

  state_t               state_q, state_d;
  logic [15:0]          beat_q, beat_d;
  logic [15:0]          line_q, line_d;
  logic [15:0]          frame_h_q, frame_h_d;
  logic                 bad_q, bad_d;
  logic [P_VID_DAT-1:0] acc_q, acc_d;
  logic [15:0]          hres_q, hres_d;
  logic [15:0]          vres_q, vres_d;
  logic [P_VID_DAT-1:0] chk_q, chk_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 stb_q, stb_d;
  logic [2:0]           err_q, err_d;
  logic [3:0]           match_q, match_d;
  logic                 lock_q, lock_d;

  logic                 start_c, cont_c, close_c;
  logic [15:0]          beats_c, lines_c, px_c;
  logic [17:0]          prod_c;
  logic [2:0]           new_err_c;
  logic [3:0]           match_n;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    frame_h_d = frame_h_q;
    bad_d     = bad_q;
    acc_d     = acc_q;
    hres_d    = hres_q;
    vres_d    = vres_q;
    chk_d     = chk_q;
    cnt_d     = cnt_q;
    stb_d     = 1'b0;
    err_d     = err_q;
    match_d   = match_q;
    lock_d    = lock_q;
    start_c   = 1'b0;
    cont_c    = 1'b0;
    close_c   = 1'b0;
    beats_c   = beat_q;
    lines_c   = line_q;
    prod_c    = '0;
    px_c      = '0;
    new_err_c = '0;
    match_n   = match_q;

    if (VID_VLD_IN) begin
      case (state_q)
        S_IDLE: start_c = VID_SOF_IN;
        S_LINE: begin
          if (VID_SOF_IN) begin
            start_c      = 1'b1;
            new_err_c[0] = 1'b1;
          end else begin
            cont_c = 1'b1;
          end
        end
        S_EOL: begin
          if (VID_SOF_IN) begin
            start_c = 1'b1;
            close_c = 1'b1;
          end else begin
            cont_c = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A SOF beat is always beat 1 of a fresh frame, whatever it closed or aborted.
    if (start_c) begin
      beats_c = 16'd1;
      lines_c = 16'd0;
      acc_d   = VID_DAT_IN;
      bad_d   = 1'b0;
      state_d = S_LINE;
    end else if (cont_c) begin
      beats_c = (beat_q == 16'hFFFF) ? beat_q : beat_q + 16'd1;
      acc_d   = acc_q ^ VID_DAT_IN;
      state_d = S_LINE;
    end
    beat_d = beats_c;
    line_d = lines_c;

    if ((start_c || cont_c) && VID_EOL_IN) begin
      prod_c = 18'(beats_c) * 18'(P_PPC);
      px_c   = (prod_c > 18'h0FFFF) ? 16'hFFFF : prod_c[15:0];
      if (lines_c == 16'd0) begin
        frame_h_d = px_c;
      end else if (px_c != frame_h_q) begin
        new_err_c[1] = 1'b1;
        bad_d        = 1'b1;
      end
      line_d  = (lines_c == 16'hFFFF) ? lines_c : lines_c + 16'd1;
      beat_d  = 16'd0;
      state_d = S_EOL;
    end

    if (close_c) begin
      hres_d = frame_h_q;
      vres_d = line_q;
      chk_d  = acc_q;
      stb_d  = 1'b1;
      // A zero match count means there is no trusted previous frame to compare against.
      if (match_q == 4'd0) begin
        match_n = 4'd1;
        lock_d  = (LOCK_N == 4'd1);
      end else if (frame_h_q == hres_q && line_q == vres_q && !bad_q) begin
        match_n = (match_q >= LOCK_N) ? LOCK_N : match_q + 4'd1;
        lock_d  = (match_n == LOCK_N);
      end else begin
        match_n = 4'd1;
        lock_d  = 1'b0;
        if (line_q != vres_q) new_err_c[2] = 1'b1;
      end
    end

    if (new_err_c[0]) begin
      match_n = 4'd0;
      lock_d  = 1'b0;
    end
    match_d = match_n;

    if (CLR_IN) begin
      cnt_d = close_c ? 16'd1 : 16'd0;
    end else if (close_c) begin
      cnt_d = cnt_q + 16'd1;
    end
    err_d = (CLR_IN ? 3'b000 : err_q) | new_err_c;
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      line_q    <= '0;
      frame_h_q <= '0;
      bad_q     <= 1'b0;
      acc_q     <= '0;
      hres_q    <= '0;
      vres_q    <= '0;
      chk_q     <= '0;
      cnt_q     <= '0;
      stb_q     <= 1'b0;
      err_q     <= '0;
      match_q   <= '0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      frame_h_q <= frame_h_d;
      bad_q     <= bad_d;
      acc_q     <= acc_d;
      hres_q    <= hres_d;
      vres_q    <= vres_d;
      chk_q     <= chk_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
      match_q   <= match_d;
      lock_q    <= lock_d;
    end
  end

  assign LOCK_OUT    = lock_q;
  assign HRES_OUT    = hres_q;
  assign VRES_OUT    = vres_q;
  assign CHK_OUT     = chk_q;
  assign FRM_CNT_OUT = cnt_q;
  assign FRM_STB_OUT = stb_q;
  assign ERR_OUT     = err_q;

endmodule
